// File: rtl/result_ascii_formatter_pkg.sv
// Shared types and ASCII constants for the Euler result formatter.
// Pure declarations; no timing or flow-control behaviour of its own.
package euler_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2,
    FINISH  = 2'd3
  } fmt_state_e;

  typedef enum logic [1:0] {
    SEL_DIGIT = 2'd0,
    SEL_CR    = 2'd1,
    SEL_LF    = 2'd2
  } emit_sel_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble: WIDTH iterations after start, bcd_valid one edge after the last.
// No backpressure; bcd_nxt/last expose the final iteration so a consumer can act on the same edge.
module bin2bcd_dd #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_nxt,
  output logic                  last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] bcd_shift;
  logic [WIDTH-1:0]    shift_shift;

  always_comb begin
    // +3 per nibble only; a nibble <= 9 plus 3 never carries out of 4 bits
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift   = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
    shift_shift = {shift_q[WIDTH-2:0], 1'b0};
    last        = busy_q && (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    if (start) begin
      shift_d = din;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
    end else if (busy_q) begin
      shift_d = shift_shift;
      bcd_d   = bcd_shift;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign bcd_nxt   = bcd_shift;

endmodule

// File: rtl/result_ascii_formatter.sv
// Captures result on a rising done, converts to BCD and streams ASCII digits (+CR LF); first byte WIDTH cycles after trigger.
// tx_valid is held with stable tx_data until tx_ready; one byte per cycle with no bubbles when ready stays high.
module result_ascii_formatter
  import euler_fmt_pkg::*;
#(
  parameter int WIDTH     = 20,
  parameter int DIGITS    = 7,
  parameter int TERMINATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    result,
  input  logic                done,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                busy,
  output logic                finished
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  fmt_state_e          state_q, state_d;
  emit_sel_e           sel_q, sel_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                done_q;

  logic                trigger;
  logic                dd_busy, dd_valid, dd_last;
  logic [4*DIGITS-1:0] dd_bcd, dd_bcd_nxt;
  logic [PW-1:0]       start_ptr, ptr_m1;
  logic [3:0]          start_dig, next_dig;
  logic                fin;

  assign trigger = done && !done_q && ((state_q == IDLE) || (state_q == FINISH));
  assign ptr_m1  = ptr_q - PW'(1);

  bin2bcd_dd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk       (clk),
    .rst       (rst),
    .start     (trigger),
    .din       (result),
    .busy      (dd_busy),
    .bcd       (dd_bcd),
    .bcd_valid (dd_valid),
    .bcd_nxt   (dd_bcd_nxt),
    .last      (dd_last)
  );

  // Leading-digit search runs on the final iteration's value so the first byte is ready on that edge
  always_comb begin
    start_ptr = '0;
    start_dig = dd_bcd_nxt[3:0];
    for (int i = 1; i < DIGITS; i++) begin
      if (dd_bcd_nxt[4*i +: 4] != 4'h0) begin
        start_ptr = PW'(i);
        start_dig = dd_bcd_nxt[4*i +: 4];
      end
    end
    next_dig = dd_bcd[3:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (PW'(i) == ptr_m1) next_dig = dd_bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    finished_d = finished_q;
    fin        = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        if (trigger) begin
          state_d    = CONVERT;
          busy_d     = 1'b1;
          finished_d = 1'b0;
        end
      end
      CONVERT: begin
        if (dd_busy && dd_last) begin
          state_d    = EMIT;
          sel_d      = SEL_DIGIT;
          ptr_d      = start_ptr;
          tx_data_d  = digit_ascii(start_dig);
          tx_valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (tx_valid_q && tx_ready) begin
          case (sel_q)
            SEL_DIGIT: begin
              if (ptr_q != '0) begin
                ptr_d     = ptr_m1;
                tx_data_d = digit_ascii(next_dig);
              end else if (TERMINATE != 0) begin
                sel_d     = SEL_CR;
                tx_data_d = ASCII_CR;
              end else begin
                fin = 1'b1;
              end
            end
            SEL_CR: begin
              sel_d     = SEL_LF;
              tx_data_d = ASCII_LF;
            end
            default: fin = 1'b1;
          endcase
        end
        if (fin) begin
          state_d    = FINISH;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          finished_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= SEL_DIGIT;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      done_q     <= done;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign bcd       = dd_bcd;
  assign bcd_valid = dd_valid;

endmodule

// File: tb/tb_result_ascii_formatter.sv
// Directed bench for result_ascii_formatter: expected strings, BCD values and cycle counts are hand-derived.
module tb_result_ascii_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] result = '0;
  logic        done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [27:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        finished;

  int total = 0;
  int bad   = 0;
  byte unsigned got[$];

  always #5 clk = ~clk;

  result_ascii_formatter #(.WIDTH(20), .DIGITS(7), .TERMINATE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .result    (result),
    .done      (done),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .finished  (finished)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drops done for one edge, then raises it with value v; returns at the negedge after the trigger edge.
  task automatic trig(input logic [19:0] v);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    result = v;
    done   = 1'b1;
    @(negedge clk);
  endtask

  // Collects accepted bytes; k counts negedges after the trigger edge (k=0 is just after it).
  task automatic run_string(input bit bp, input int limit, output int first_vld, output int fin_cyc);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat   = '0;
    first_vld = -1;
    fin_cyc   = -1;
    got.delete();
    for (int k = 0; k < limit; k++) begin
      if (finished) begin
        fin_cyc = k;
        break;
      end
      if (prev_stall && tx_valid) check("stall_data", tx_data, prev_dat);
      if (tx_valid && first_vld < 0) first_vld = k;
      tx_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
      @(negedge clk);
    end
    tx_ready = 1'b1;
  endtask

  task automatic check_str(input string tag, input string exp);
    int n = exp.len();
    check({tag, "_len"}, got.size(), n + 2);
    for (int i = 0; i < n; i++)
      if (i < got.size()) check({tag, "_dig"}, got[i], exp[i]);
    if (got.size() > n)     check({tag, "_cr"}, got[n], 8'h0D);
    if (got.size() > n + 1) check({tag, "_lf"}, got[n + 1], 8'h0A);
  endtask

  // Counts cycles with tx_valid high over a quiet window.
  task automatic quiet_window(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int fv, fc;

    // Reset state
    #12;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_bcd", bcd, 0);
    check("rst_bcd_valid", bcd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1. Nominal 906609 with timing
    trig(20'd906609);
    check("t1_busy", busy, 1);
    check("t1_bcd_valid_lo", bcd_valid, 0);
    run_string(1'b0, 200, fv, fc);
    check("t1_first_vld", fv, 20);
    check("t1_fin_cyc", fc, 28);
    check("t1_b0", got.size() > 0 ? got[0] : 8'hFF, 8'h39);
    check_str("t1", "906609");
    check("t1_bcd", bcd, 28'h0906609);
    check("t1_bcd_valid", bcd_valid, 1);
    check("t1_busy_end", busy, 0);

    // 2. Zero
    trig(20'd0);
    run_string(1'b0, 200, fv, fc);
    check("t2_fin_cyc", fc, 23);
    check_str("t2", "0");
    check("t2_bcd", bcd, 28'h0);
    check("t2_bcd_valid", bcd_valid, 1);

    // 3. Maximum
    trig(20'd1048575);
    run_string(1'b0, 200, fv, fc);
    check("t3_bcd", bcd, 28'h1048575);
    check_str("t3", "1048575");

    // 4. Backpressure
    trig(20'd906609);
    run_string(1'b1, 3000, fv, fc);
    check("t4_finished", fc >= 0, 1);
    check_str("t4", "906609");

    // 5. Reset after three accepted bytes (handshakes at edges N+21..N+23)
    trig(20'd906609);
    repeat (23) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_tx_valid", tx_valid, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_bcd", bcd, 0);
    check("t5_bcd_valid", bcd_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_finished", finished, 0);
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    trig(20'd906609);
    run_string(1'b0, 200, fv, fc);
    check("t5_b0", got.size() > 0 ? got[0] : 8'hFF, 8'h39);
    check_str("t5", "906609");

    // 6a. done already high at reset release: the first clock triggers, once
    @(negedge clk);
    rst    = 1'b1;
    result = 20'd555;
    done   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6a_busy", busy, 1);
    run_string(1'b0, 200, fv, fc);
    check("t6a_first_vld", fv, 20);
    check_str("t6a", "555");
    quiet_window("t6a_no_second", 40);

    // 6b. done toggled during CONVERT is ignored
    trig(20'd4095);
    repeat (5) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    done = 1'b1;
    run_string(1'b0, 200, fv, fc);
    check_str("t6b", "4095");
    quiet_window("t6b_no_second", 40);

    // 6c. Retrigger from FINISH with a new value
    check("t6c_finished_hold", finished, 1);
    trig(20'd12);
    check("t6c_finished_clr", finished, 0);
    run_string(1'b0, 200, fv, fc);
    check("t6c_fin_cyc", fc, 24);
    check_str("t6c", "12");
    check("t6c_bcd", bcd, 28'h0000012);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_ascii_formatter.md
# result_ascii_formatter

Downstream stage of the Euler solver cores (e.g. the palindrome-product solver), which expose a `result`/`done` pair. On the rising edge of `done` the block captures `result` and converts it to BCD with a sequential double-dabble engine. It then streams the value as ASCII decimal text, without leading zeros and followed by CR LF, over a byte-wide valid/ready interface toward the UART transmitter.

## Interface

**Parameters**

- `WIDTH`, default 20: binary result width.
- `DIGITS`, default 7: BCD digits. Must satisfy 10^DIGITS > 2^WIDTH − 1. The default covers 1048575.
- `TERMINATE`, default 1: when 1, append 0x0D, 0x0A after the digits.

**Ports**

- `clk`, input, 1: clock. All state changes on rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `result`, input, WIDTH: solver answer. Sampled only on the trigger cycle.
- `done`, input, 1: solver completion flag. Sticky high upstream.
- `tx_data`, output, 8: ASCII byte.
- `tx_valid`, output, 1: `tx_data` is offered.
- `tx_ready`, input, 1: sink accepts. A byte transfers on an edge where `tx_valid && tx_ready`.
- `bcd`, output, 4*DIGITS: converted value. Digit DIGITS−1 is most significant.
- `bcd_valid`, output, 1: `bcd` holds the converted value of the last capture.
- `busy`, output, 1: capture through last byte accepted.
- `finished`, output, 1: the full string has been sent.

## Operation

**Trigger**

- `done_q` is a registered copy of `done`, reset to 0.
- trigger = `done && !done_q` while in IDLE or FINISH.
- If `done` is already high when reset is released, the first clock is a trigger.
- `done` edges in CONVERT or EMIT are ignored and are not queued.

**State machine**

- IDLE → CONVERT on trigger. Latch `result` into the shift register. Clear the BCD register and the iteration counter. Set `busy`. Clear `bcd_valid` and `finished`.
- CONVERT runs exactly WIDTH iterations, one per clock. Each iteration:
  - every BCD nibble ≥ 5 gets +3;
  - {bcd, shift} is shifted left by 1.
- After the last iteration: `bcd_valid` = 1.
- Start pointer = index of the most significant nonzero digit. The pointer is 0 if the value is 0, so 0 emits "0".
- CONVERT → EMIT after the last iteration.
- EMIT:
  - `tx_data` = 0x30 + digit[ptr], then 0x0D and 0x0A if TERMINATE.
  - Advance only on handshake.
  - After the last byte is accepted: `busy` = 0, `finished` = 1, → FINISH.
- FINISH holds `finished` and `bcd`. A new trigger restarts exactly as from IDLE.

**Arithmetic and width rules**

- The +3 correction is applied per nibble, 4 bits wide, with no carry between nibbles.
- The iteration counter is $clog2(WIDTH+1) bits wide.
- No overflow is possible under the DIGITS constraint.

**Handshake rules**

- Once raised, `tx_valid` stays high until the handshake.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- `tx_valid` never depends combinationally on `tx_ready`.

**Reset**

- All outputs are 0 at reset: `tx_data`, `tx_valid`, `bcd`, `bcd_valid`, `busy`, `finished`.
- State returns to IDLE.
- Reset mid-operation takes effect immediately and asynchronously. `tx_valid` drops without a handshake. The partial string is abandoned, and a later trigger re-emits the whole string.

## Timing

- Trigger sampled at edge N: `busy` goes high after edge N.
- Conversion iterations occur at edges N+1 … N+WIDTH.
- `bcd_valid` and `tx_valid` go high after edge N+WIDTH.
- With `tx_ready` held high: one byte per cycle, and `finished` goes high after edge N+WIDTH+B, where B = emitted bytes (digits + 2·TERMINATE).
- Zero-cycle bubbles between bytes of one string.
- All outputs are registered.

## Structure

- Shared package `euler_fmt_pkg`:
  - state enum (IDLE, CONVERT, EMIT, FINISH);
  - ASCII constants `ASCII_ZERO` = 0x30, `ASCII_CR` = 0x0D, `ASCII_LF` = 0x0A.
- One sub-module, `bin2bcd_dd`. It is a parameterised (WIDTH, DIGITS) sequential double-dabble with `start`/`busy`/`bcd`/`bcd_valid`.
- The formatter FSM, trigger detect and byte pointer live in `result_ascii_formatter`.

## Test plan

1. **Nominal value.** `result` = 906609, `done` rises, `tx_ready` = 1. Expect bytes 0x39 0x30 0x36 0x36 0x30 0x39 0x0D 0x0A, with `tx_valid` first high after edge N+20 and `finished` after edge N+28.
2. **Zero.** `result` = 0. Expect bytes 0x30 0x0D 0x0A and `bcd` = 0.
3. **Maximum value.** `result` = 1048575. Expect `bcd` = 0x1048575 and string "1048575" CR LF.
4. **Backpressure.** Random `tx_ready` (≈30% high) with `result` = 906609. Expect `tx_data` constant across every stall and the identical 8-byte sequence.
5. **Reset mid-stream.** Assert `rst` after 3 bytes are accepted. Expect all outputs 0 in the same cycle. Release `rst` and raise `done` again; expect the full string from 0x39.
6. **Trigger edge cases.**
   - `done` high at reset release gives exactly one string.
   - Toggling `done` during CONVERT gives no second string.
   - Toggling `done` in FINISH restarts with the new `result` = 12, giving "12" CR LF.
